// File: rtl/ps2_arrow_decoder_if.sv
// Event handshake between the arrow-key decoder and the game logic.
// The master queues events and the slave accepts the head one with event_ready.
interface ps2_arrow_decoder_if;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_lane;
  logic       event_release;

  modport master (output event_valid, output event_lane, output event_release, input event_ready);
  modport slave  (input event_valid, input event_lane, input event_release, output event_ready);
endinterface

// File: rtl/ps2_arrow_decoder.sv
// Set-2 scancode parser: tracks the four arrow lanes and queues press/release events.
// The optional macro PS2_WASD_LANES_EN maps the non-extended W/A/S/D keys onto the same lanes.
module ps2_arrow_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           received_data,
  input  logic                 received_data_en,
  output logic [3:0]           key_held,
  ps2_arrow_decoder_if.master  evt,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Returns {hit, lane}
  function automatic logic [2:0] arrow_code(input logic [7:0] b);
    case (b)
      8'h6B:   arrow_code = 3'b100;
      8'h72:   arrow_code = 3'b101;
      8'h75:   arrow_code = 3'b110;
      8'h74:   arrow_code = 3'b111;
      default: arrow_code = 3'b000;
    endcase
  endfunction

`ifdef PS2_WASD_LANES_EN
  function automatic logic [2:0] wasd_code(input logic [7:0] b);
    case (b)
      8'h1C:   wasd_code = 3'b100;
      8'h1B:   wasd_code = 3'b101;
      8'h1D:   wasd_code = 3'b110;
      8'h23:   wasd_code = 3'b111;
      default: wasd_code = 3'b000;
    endcase
  endfunction
`endif

  state_t        state, state_nxt;
  logic [TW-1:0] tcount;
  logic          is_make, is_break, push;
  logic [1:0]    lane;
  logic [2:0]    arw;
  logic [2:0]    push_data;

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    lane      = 2'd0;
    arw       = arrow_code(received_data);
    if (received_data_en) begin
      case (state)
        IDLE: begin
          if (received_data == 8'hE0)      state_nxt = EXT;
          else if (received_data == 8'hF0) state_nxt = BRK;
`ifdef PS2_WASD_LANES_EN
          else if (wasd_code(received_data) != 3'b000) begin
            is_make = 1'b1;
            lane    = wasd_code(received_data) & 3'b011;
          end
`endif
        end
        EXT: begin
          if (received_data == 8'hF0)      state_nxt = EXT_BRK;
          else if (received_data == 8'hE0) state_nxt = EXT;
          else begin
            state_nxt = IDLE;
            is_make   = arw[2];
            lane      = arw[1:0];
          end
        end
        BRK: begin
          if (received_data != 8'hF0) begin
            state_nxt = IDLE;
`ifdef PS2_WASD_LANES_EN
            is_break  = wasd_code(received_data) != 3'b000;
            lane      = wasd_code(received_data) & 3'b011;
`endif
          end
        end
        default: begin
          state_nxt = IDLE;
          is_break  = arw[2];
          lane      = arw[1:0];
        end
      endcase
    end else if (state != IDLE && tcount == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = IDLE;
    end
  end

  // Repeats of a held key and breaks of an unheld key generate nothing
  assign push      = (is_make & ~key_held[lane]) | (is_break & key_held[lane]);
  assign push_data = {lane, is_break};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tcount   <= '0;
      key_held <= 4'd0;
    end else begin
      state <= state_nxt;
      if (received_data_en || state == IDLE || state_nxt == IDLE) tcount <= '0;
      else                                                        tcount <= tcount + 1'b1;
      if (push) key_held[lane] <= is_make;
    end
  end

  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          valid_q, pop, full, wr_ok;
  logic [2:0]    head_q, head_nxt;

  assign pop       = valid_q & evt.event_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign wr_ok     = push & (~full | pop);
  assign count_nxt = count + CW'(wr_ok) - CW'(pop);
  assign rd_nxt    = rd_ptr + AW'(pop);

  // Head is registered; a push into an otherwise empty queue becomes the head directly
  always_comb begin
    head_nxt = 3'd0;
    if (count_nxt != '0) begin
      if (wr_ok && count == CW'(pop)) head_nxt = push_data;
      else                            head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      head_q   <= 3'd0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_nxt;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      count    <= count_nxt;
      valid_q  <= (count_nxt != '0);
      head_q   <= head_nxt;
      overflow <= (push & full & ~pop) | (overflow & ~clear_overflow);
    end
  end

  assign evt.event_valid   = valid_q;
  assign evt.event_lane    = head_q[2:1];
  assign evt.event_release = head_q[0];

endmodule
